// File: rtl/vector_norm_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// GAM_package
// Shared definitions for the vector norm sequencer:
//   VECTOR_LEN    - number of elements per input vector
//   norm_state_t  - sequencer FSM states
//   DEFAULT_SUM_W - default sum-of-squares accumulator width
//   NORM_W        - root width for the default accumulator width
//   norm_width()  - root width for an arbitrary accumulator width
// -----------------------------------------------------------------------------
package GAM_package;

  localparam int VECTOR_LEN    = 4;
  localparam int DEFAULT_SUM_W = 32;
  localparam int NORM_W        = DEFAULT_SUM_W / 2;

  typedef enum logic [1:0] {
    IDLE,
    SQUARE,
    SQRT,
    DONE
  } norm_state_t;

  // floor(sqrt(x)) of a sum_w-bit value always fits in sum_w/2 bits.
  function automatic int norm_width(input int sum_w);
    return sum_w / 2;
  endfunction

endpackage

// File: rtl/vector_norm_sequencer_isqrt.sv
// -----------------------------------------------------------------------------
// norm_isqrt_unit
// Iterative integer square root by summing odd numbers, one step per cycle.
// sq walks through the perfect squares 1, 4, 9, ... while delta walks through
// the odd numbers 3, 5, 7, ...; the first square exceeding the operand ends
// the loop and the root is (delta >> 1) - 1.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   start_i    - load sq=1, delta=3 and begin iterating
//   operand_i  - value to root; must stay stable while busy_o is high
//   busy_o     - loop running
//   done_o     - high on the final (terminating) cycle of the loop
//   root_o     - floor(sqrt(operand_i)), held until the next completion
// -----------------------------------------------------------------------------
module norm_isqrt_unit #(
  parameter int SUM_W  = 32,
  parameter int NORM_W = SUM_W / 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [SUM_W-1:0]  operand_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [NORM_W-1:0] root_o
);

  // Two extra bits each: the terminating square can reach 2^SUM_W and the
  // terminating odd number 2^(NORM_W+1)+1, and neither may wrap.
  localparam int SQ_W    = SUM_W + 2;
  localparam int DELTA_W = NORM_W + 2;

  logic               busy_q, busy_d;
  logic [SQ_W-1:0]    sq_q, sq_d;
  logic [DELTA_W-1:0] delta_q, delta_d;
  logic [NORM_W-1:0]  root_q, root_d;
  logic               fits;

  assign fits   = sq_q <= SQ_W'(operand_i);
  assign done_o = busy_q && !fits;
  assign busy_o = busy_q;
  assign root_o = root_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      sq_q    <= '0;
      delta_q <= '0;
      root_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      sq_q    <= sq_d;
      delta_q <= delta_d;
      root_q  <= root_d;
    end
  end

  always_comb begin
    busy_d  = busy_q;
    sq_d    = sq_q;
    delta_d = delta_q;
    root_d  = root_q;
    if (start_i) begin
      sq_d    = SQ_W'(1);
      delta_d = DELTA_W'(3);
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (fits) begin
        sq_d    = sq_q + SQ_W'(delta_q);
        delta_d = delta_q + DELTA_W'(2);
      end else begin
        root_d = NORM_W'((delta_q >> 1) - DELTA_W'(1));
        busy_d = 1'b0;
      end
    end
  end

endmodule

// File: rtl/vector_norm_sequencer.sv
// -----------------------------------------------------------------------------
// vector_norm_sequencer
// Computes floor(sqrt(sum of squares)) of one unsigned vector of VECTOR_LEN
// elements. One element is squared and accumulated per cycle, then the
// isqrt unit runs one iteration per cycle. Valid/ready on both sides, no
// input skid: a new vector is only taken in IDLE.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid / in_ready - input handshake for vec_in
//   vec_in              - element i at vec_in[i*ELEM_W +: ELEM_W]
//   out_valid/out_ready - result handshake
//   sum_sq              - saturated sum of squares
//   norm_out            - floor(sqrt(sum_sq))
//   overflow            - accumulator saturated while summing this vector
// Result fields are only updated on entry to DONE and hold otherwise.
// -----------------------------------------------------------------------------
module vector_norm_sequencer
  import GAM_package::*;
#(
  parameter int ELEM_W = 8,
  parameter int SUM_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [VECTOR_LEN*ELEM_W-1:0] vec_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SUM_W-1:0]             sum_sq,
  output logic [SUM_W/2-1:0]           norm_out,
  output logic                         overflow
);

  localparam int RES_W = norm_width(SUM_W);
  localparam int IDX_W = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_LEN - 1);

  norm_state_t                  state_q, state_d;
  logic [VECTOR_LEN*ELEM_W-1:0] vec_q, vec_d;
  logic [SUM_W-1:0]             acc_q, acc_d;
  logic                         acc_ovf_q, acc_ovf_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [SUM_W-1:0]             sum_sq_q, sum_sq_d;
  logic                         ovf_q, ovf_d;

  logic                         isq_start;
  logic                         isq_busy;
  logic                         isq_done;
  logic [RES_W-1:0]             isq_root;

  // Unpack the captured vector into elements.
  logic [ELEM_W-1:0] elem [VECTOR_LEN];
  for (genvar gi = 0; gi < VECTOR_LEN; gi++) begin : g_elem
    assign elem[gi] = vec_q[gi*ELEM_W +: ELEM_W];
  end

  logic [ELEM_W-1:0]   cur_elem;
  logic [2*ELEM_W-1:0] prod;
  logic [SUM_W:0]      acc_sum;

  assign cur_elem = elem[idx_q];
  assign prod     = {{ELEM_W{1'b0}}, cur_elem} * {{ELEM_W{1'b0}}, cur_elem};
  // One extra bit so the carry out of SUM_W is visible for saturation.
  assign acc_sum  = {1'b0, acc_q} + (SUM_W+1)'(prod);

  norm_isqrt_unit #(
    .SUM_W  (SUM_W),
    .NORM_W (RES_W)
  ) u_isqrt (
    .clk       (clk),
    .rst       (rst),
    .start_i   (isq_start),
    .operand_i (acc_q),
    .busy_o    (isq_busy),
    .done_o    (isq_done),
    .root_o    (isq_root)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      idx_q     <= '0;
      sum_sq_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      idx_q     <= idx_d;
      sum_sq_q  <= sum_sq_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    idx_d     = idx_q;
    sum_sq_d  = sum_sq_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    isq_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          vec_d     = vec_in;
          acc_d     = '0;
          acc_ovf_d = 1'b0;
          idx_d     = '0;
          state_d   = SQUARE;
        end
      end
      SQUARE: begin
        if (acc_sum[SUM_W]) begin
          acc_d     = '1;
          acc_ovf_d = 1'b1;
        end else begin
          acc_d = acc_sum[SUM_W-1:0];
        end
        idx_d = idx_q + 1'b1;
        // The root loop is armed on the same edge that stores the final
        // sum, so its first comparison already sees the complete acc.
        if (idx_q == LAST_IDX) begin
          idx_d     = '0;
          isq_start = 1'b1;
          state_d   = SQRT;
        end
      end
      SQRT: begin
        if (isq_busy && isq_done) begin
          sum_sq_d = acc_q;
          ovf_d    = acc_ovf_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sum_sq   = sum_sq_q;
  assign norm_out = isq_root;
  assign overflow = ovf_q;

endmodule

// File: doc/vector_norm_sequencer.md
# vector_norm_sequencer

- Computes the integer Euclidean norm floor(sqrt(sum of squares)) of one unsigned vector of VECTOR_LEN elements.
- Sequences a single square-accumulate datapath, one element per cycle, then an iterative odd-number square root, one iteration per cycle.
- Sits between the vector load path and the result consumer; valid/ready handshakes on both sides.

## Interface

Parameters:
- ELEM_W, 8, unsigned element width.
- VECTOR_LEN, from GAM_package, number of elements per vector.
- SUM_W, 32, sum-of-squares accumulator width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  vec_in is valid.
- in_ready  out  1  block can accept a vector.
- vec_in  in  VECTOR_LEN*ELEM_W  element i is vec_in[i*ELEM_W +: ELEM_W], unsigned.
- out_valid  out  1  result fields are valid.
- out_ready  in  1  consumer accepts the result.
- sum_sq  out  SUM_W  sum of squares, saturated.
- norm_out  out  SUM_W/2  floor(sqrt(sum_sq)).
- overflow  out  1  accumulator saturated during this vector.

## Operation

State machine (norm_state_t): IDLE, SQUARE, SQRT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture vec_in, clear acc/overflow, idx=0, go to SQUARE.
- SQUARE:
  - Each cycle, acc += vec[idx]*vec[idx] (2*ELEM_W product, zero-extended), then idx++.
  - Carry out of SUM_W forces acc to all-ones and sets overflow (sticky until next acceptance).
  - After idx=VECTOR_LEN-1 is processed, initialise sq=1, delta=3 and go to SQRT.
- SQRT:
  - Each cycle, if sq<=acc: sq+=delta, delta+=2.
  - Otherwise: norm_out=(delta>>1)-1, go to DONE.
  - Width of sq is SUM_W+2 bits; width of delta is SUM_W/2+2 bits. No wrap is permitted.
- DONE:
  - out_valid=1; sum_sq, norm_out and overflow are held stable.
  - On out_ready, go to IDLE.
- Outside IDLE, in_ready=0: there is no input skid and no bypass. vec_in is ignored while busy.
- Outside DONE, out_valid=0. Output fields keep their last values.

## Timing

Reset:
- State IDLE, in_ready=1, out_valid=0.
- sum_sq=0, norm_out=0, overflow=0.
- Internal acc, idx, sq and delta are cleared.
- Reset mid-operation (any state) abandons the vector; the next cycle is IDLE with reset values. No result is emitted.

Latency, with acceptance edge = edge 0:
- SQUARE occupies edges 1..VECTOR_LEN.
- SQRT occupies isqrt(S)+1 edges, where S = final acc.
- out_valid first high after edge VECTOR_LEN+isqrt(S)+1.
- Worst case is data-dependent, bounded by VECTOR_LEN+2^(SUM_W/2)+1.

Handshakes:
- Transfer happens on a cycle with valid&ready high.
- out_valid, once high, stays high with stable fields until the transfer.
- out_ready high while out_valid is low has no effect.
- Back-to-back: the result transfer edge returns to IDLE, and in_ready is high the following cycle. Minimum spacing between acceptances is VECTOR_LEN+isqrt(S)+3 cycles.

## Structure

GAM_package holds:
- VECTOR_LEN.
- typedef enum norm_state_t {IDLE, SQUARE, SQRT, DONE}.
- localparam NORM_W = SUM_W/2.

Sub-module: norm_isqrt_unit.
- Ports: start/busy/done, SUM_W operand in, NORM_W root out.
- Owns sq, delta and the SQRT loop.
- vector_norm_sequencer keeps the FSM, capture register, square-accumulate and handshakes.

## Test plan

Bench uses VECTOR_LEN=4, ELEM_W=8, SUM_W=32.
- {3,4,0,0}, out_ready=1 -> sum_sq=25, norm_out=5, overflow=0, out_valid 10 cycles after acceptance, for exactly 1 cycle.
- {0,0,0,0} -> sum_sq=0, norm_out=0, latency 5. Then {1,2,3,0} -> sum_sq=14, norm_out=3, latency 8.
- {255,255,255,255} -> sum_sq=260100, norm_out=510, latency 515, overflow=0. in_valid is held high throughout and in_ready stays 0 until return to IDLE.
- {1,1,1,1} with out_ready low 6 cycles after out_valid:
  - sum_sq=4, norm_out=2, held stable for all 7 cycles.
  - in_ready=0 throughout; a second vector presented then is not accepted.
  - After the transfer, in_ready=1 next cycle and the second vector is accepted.
- rst pulsed during SQRT of {255,255,255,255}:
  - Next cycle: IDLE, in_ready=1, out_valid=0, all outputs 0.
  - No stale result ever appears.
  - A following {3,4,0,0} yields norm_out=5.
- Overflow with a SUM_W=16 build, {255,255,0,0}:
  - sum_sq=16'hFFFF, overflow=1, norm_out=255.
  - A subsequent {3,4,0,0} clears overflow to 0.
